// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM encoding,
// owner IDs and default timing parameters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 3;

    // Bits needed to hold 0..max_val; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// sat_o tells the arbiter that the fetch port must win the next contention.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam int CNT_W = cnt_width(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat_o = (cnt_q == CNT_W'(MAX));

    // Clear dominates; counting stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch and data) in front of one single-port memory.
// One transaction at a time: IDLE -> ISSUE -> WAIT* -> RESP -> IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int LAT_W     = cnt_width(MEM_LAT);
    localparam int WAIT_LOAD = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

    arb_state_t        state_q,   state_d;
    owner_t            owner_q,   owner_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              we_q,      we_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;

    logic in_idle;
    logic in_issue;
    logic in_resp;
    logic any_req;
    logic if_wins;
    logic starve_sat;
    logic starve_inc;
    logic starve_clr;

    assign in_idle  = (state_q == IDLE);
    assign in_issue = (state_q == ISSUE);
    assign in_resp  = (state_q == RESP);

    // Data normally wins a tie; a saturated starvation count hands it to fetch.
    assign any_req = bus.if_req | bus.d_req;
    assign if_wins = bus.if_req & (~bus.d_req | starve_sat);

    assign starve_inc = in_idle & bus.d_req & bus.if_req & ~if_wins;
    assign starve_clr = in_idle & (~bus.if_req | if_wins);

    mem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        lat_cnt_d = lat_cnt_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    if (if_wins) begin
                        owner_d = OWN_IF;
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end else begin
                        owner_d = OWN_D;
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                    end
                end
            end
            ISSUE: begin
                if (MEM_LAT > 1) begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_W'(WAIT_LOAD);
                end else begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            lat_cnt_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            lat_cnt_q  <= lat_cnt_d;
            if_valid_q <= in_resp & (owner_q == OWN_IF);
            d_valid_q  <= in_resp & (owner_q == OWN_D);
            if (in_resp && owner_q == OWN_IF) begin
                if_rdata_q <= bus.mem_rdata;
            end
            // Stores complete with a valid pulse but leave load data untouched.
            if (in_resp && owner_q == OWN_D && !we_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = in_issue;
    assign bus.mem_we    = in_issue & (owner_q == OWN_D) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_gnt    = in_issue & (owner_q == OWN_IF);
    assign bus.d_gnt     = in_issue & (owner_q == OWN_D);
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    assign bus.busy      = ~in_idle;

endmodule
